// File: rtl/axi_master_ctrl_pkg.sv
// Shared SAXI master types: address/data/ID widths and the lowest-free ID picker.
// Pure declarations, no timing or flow control of its own.
package axi_transaction;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int ID_W   = 2;
    localparam int n_ids  = 2 ** ID_W;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] data_t;
    typedef logic [ID_W-1:0]   id_t;
    typedef logic [n_ids-1:0]  id_mask_t;

    // Scanning downward leaves the lowest clear index as the final winner.
    function automatic id_t lowest_clear(input id_mask_t busy);
        id_t id;
        id = '0;
        for (int i = n_ids - 1; i >= 0; i--) begin
            if (!busy[i]) begin
                id = id_t'(i);
            end
        end
        return id;
    endfunction

endpackage

// File: rtl/axi_master_ctrl_id_alloc.sv
// Read ID pool: busy mask plus the request address parked per ID.
// Alloc/free take effect on the edge; a freed ID is visible as free from the next cycle.
module axi_id_alloc
    import axi_transaction::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  alloc,
    input  addr_t alloc_addr,
    output id_t   alloc_id,
    output logic  none_free,
    input  logic  free,
    input  id_t   free_id,
    input  id_t   lookup_id,
    output logic  lookup_busy,
    output addr_t lookup_addr
);

    id_mask_t id_busy;
    addr_t    id_addr [n_ids];

    assign alloc_id    = lowest_clear(id_busy);
    assign none_free   = &id_busy;
    assign lookup_busy = id_busy[lookup_id];
    assign lookup_addr = id_addr[lookup_id];

    // alloc only ever targets a clear bit and free a set one, so they never collide.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            id_busy <= '0;
        end else begin
            if (free) begin
                id_busy[free_id] <= 1'b0;
            end
            if (alloc) begin
                id_busy[alloc_id] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (alloc) begin
            id_addr[alloc_id] <= alloc_addr;
        end
    end

endmodule

// File: rtl/axi_master_ctrl.sv
// SAXI master: one user request stream to AR/AW/W, out-of-order reads by ID, in-order B counting.
// Channel valids one cycle after accept; req_ready drops when the target channel or ID/write budget is full.
module axi_master_ctrl
    import axi_transaction::*;
#(
    parameter int MAX_WR_OUT = 4,
    parameter int CNT_W      = 4
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  req_valid,
    output logic  req_ready,
    input  logic  req_write,
    input  addr_t req_addr,
    input  data_t req_wdata,
    output logic  rd_rsp_valid,
    input  logic  rd_rsp_ready,
    output id_t   rd_rsp_id,
    output addr_t rd_rsp_addr,
    output data_t rd_rsp_data,
    output logic  wr_done,
    output logic  protocol_err,
    output addr_t araddr,
    output id_t   arid,
    output logic  arvalid,
    input  logic  arready,
    output addr_t awaddr,
    output logic  awvalid,
    input  logic  awready,
    output data_t wdata,
    output logic  wvalid,
    input  logic  wready,
    input  data_t rdata,
    input  id_t   rid,
    input  logic  rvalid,
    output logic  rready,
    input  logic  bvalid,
    output logic  bready
);

    localparam logic [CNT_W-1:0] WR_LIMIT = CNT_W'(MAX_WR_OUT);

    logic [CNT_W-1:0] wr_cnt;
    logic             rd_slot_ok;
    logic             wr_slot_ok;
    logic             rd_accept;
    logic             wr_accept;
    logic             r_hs;
    logic             b_hs;
    logic             b_dec;
    logic             r_err;
    logic             b_err;
    id_t              alloc_id;
    logic             none_free;
    logic             id_known;
    addr_t            id_addr_lkp;

    // A slot frees up in the same cycle its current holder handshakes.
    assign rd_slot_ok = (!arvalid || arready) && !none_free;
    assign wr_slot_ok = (!awvalid || awready) && (!wvalid || wready) && (wr_cnt < WR_LIMIT);
    assign req_ready  = req_write ? wr_slot_ok : rd_slot_ok;
    assign rd_accept  = req_valid && !req_write && rd_slot_ok;
    assign wr_accept  = req_valid && req_write && wr_slot_ok;

    assign rready = !rd_rsp_valid || rd_rsp_ready;
    assign r_hs   = rvalid && rready;
    assign b_hs   = bvalid && bready;
    assign b_dec  = b_hs && (wr_cnt != '0);
    assign r_err  = r_hs && !id_known;
    assign b_err  = b_hs && (wr_cnt == '0);

    axi_id_alloc u_id_alloc (
        .clk         (clk),
        .rst         (rst),
        .alloc       (rd_accept),
        .alloc_addr  (req_addr),
        .alloc_id    (alloc_id),
        .none_free   (none_free),
        .free        (r_hs && id_known),
        .free_id     (rid),
        .lookup_id   (rid),
        .lookup_busy (id_known),
        .lookup_addr (id_addr_lkp)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            arvalid <= 1'b0;
            araddr  <= '0;
            arid    <= '0;
        end else if (rd_accept) begin
            arvalid <= 1'b1;
            araddr  <= req_addr;
            arid    <= alloc_id;
        end else if (arready) begin
            arvalid <= 1'b0;
        end
    end

    // AW and W rise together but each retires on its own handshake.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            awvalid <= 1'b0;
            awaddr  <= '0;
            wvalid  <= 1'b0;
            wdata   <= '0;
        end else if (wr_accept) begin
            awvalid <= 1'b1;
            awaddr  <= req_addr;
            wvalid  <= 1'b1;
            wdata   <= req_wdata;
        end else begin
            if (awready) begin
                awvalid <= 1'b0;
            end
            if (wready) begin
                wvalid <= 1'b0;
            end
        end
    end

    // Responses for IDs we never issued are swallowed and only flagged.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_rsp_valid <= 1'b0;
            rd_rsp_id    <= '0;
            rd_rsp_addr  <= '0;
            rd_rsp_data  <= '0;
        end else if (r_hs && id_known) begin
            rd_rsp_valid <= 1'b1;
            rd_rsp_id    <= rid;
            rd_rsp_addr  <= id_addr_lkp;
            rd_rsp_data  <= rdata;
        end else if (rd_rsp_ready) begin
            rd_rsp_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_cnt       <= '0;
            wr_done      <= 1'b0;
            protocol_err <= 1'b0;
            bready       <= 1'b0;
        end else begin
            bready  <= 1'b1;
            wr_done <= b_dec;
            if (wr_accept && !b_dec) begin
                wr_cnt <= wr_cnt + 1'b1;
            end else if (!wr_accept && b_dec) begin
                wr_cnt <= wr_cnt - 1'b1;
            end
            if (r_err || b_err) begin
                protocol_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_axi_master_ctrl.sv
// Directed scenarios followed by a randomized run against a scoreboard of expected SAXI traffic.
module tb_axi_master_ctrl;
    import axi_transaction::*;

    localparam int MAXW = 4;

    logic  clk = 1'b0;
    logic  rst;
    logic  req_valid, req_ready, req_write;
    addr_t req_addr;
    data_t req_wdata;
    logic  rd_rsp_valid, rd_rsp_ready;
    id_t   rd_rsp_id;
    addr_t rd_rsp_addr;
    data_t rd_rsp_data;
    logic  wr_done, protocol_err;
    addr_t araddr;
    id_t   arid;
    logic  arvalid, arready;
    addr_t awaddr;
    logic  awvalid, awready;
    data_t wdata;
    logic  wvalid, wready;
    data_t rdata;
    id_t   rid;
    logic  rvalid, rready, bvalid, bready;

    int n_assert = 0;
    int n_fail   = 0;
    int wd_seen  = 0;
    int wd_base;

    typedef struct {
        id_t   id;
        addr_t addr;
        data_t data;
    } rsp_t;

    addr_t exp_ar_addr [$];
    id_t   exp_ar_id   [$];
    addr_t exp_aw      [$];
    data_t exp_w       [$];
    rsp_t  exp_rsp     [$];
    id_t   pend_rd     [$];
    logic  m_busy [n_ids];
    addr_t m_addr [n_ids];
    int    m_wout, aw_cnt, w_cnt, b_issued, b_acked, wr_accepted, pick, fid;
    logic  f_req, f_ar, f_aw, f_w, f_r, f_b, f_rsp;
    rsp_t  e;
    data_t x_data;
    int    rev_id   [4] = '{2, 1, 0, 3};
    int    rev_addr [4] = '{'h8, 'h4, 'h0, 'h40};

    axi_master_ctrl #(.MAX_WR_OUT(MAXW), .CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rd_rsp_valid(rd_rsp_valid), .rd_rsp_ready(rd_rsp_ready), .rd_rsp_id(rd_rsp_id),
        .rd_rsp_addr(rd_rsp_addr), .rd_rsp_data(rd_rsp_data),
        .wr_done(wr_done), .protocol_err(protocol_err),
        .araddr(araddr), .arid(arid), .arvalid(arvalid), .arready(arready),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wvalid(wvalid), .wready(wready),
        .rdata(rdata), .rid(rid), .rvalid(rvalid), .rready(rready),
        .bvalid(bvalid), .bready(bready)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst === 1'b1 && wr_done === 1'b1) wd_seen++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not reach the end of the test");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        req_valid = 0; req_write = 0; req_addr = '0; req_wdata = '0;
        rd_rsp_ready = 1; arready = 1; awready = 1; wready = 1;
        rvalid = 0; rid = '0; rdata = '0; bvalid = 0;
    endtask

    task automatic do_reset();
        rst = 0;
        quiet();
        repeat (2) @(posedge clk);
        #1;
        rst = 1;
        tick();
    endtask

    function automatic int model_lowest_free();
        for (int i = 0; i < n_ids; i++) begin
            if (!m_busy[i]) return i;
        end
        return -1;
    endfunction

    initial begin
        x_data = 'x;
        rst = 0;
        quiet();
        #12;
        chk("rst_arvalid", arvalid, 0);
        chk("rst_awvalid", awvalid, 0);
        chk("rst_wvalid", wvalid, 0);
        chk("rst_rsp_valid", rd_rsp_valid, 0);
        chk("rst_wr_done", wr_done, 0);
        chk("rst_perr", protocol_err, 0);
        chk("rst_bready", bready, 0);
        @(posedge clk);
        #1;
        rst = 1;
        tick();
        #1;
        chk("bready_on", bready, 1);

        // write 0x10 = 0xAA, then read it back
        req_valid = 1; req_write = 1; req_addr = 'h10; req_wdata = 'hAA; #1;
        chk("wr_req_ready", req_ready, 1);
        tick(); req_valid = 0; #1;
        chk("aw_valid", awvalid, 1);
        chk("w_valid", wvalid, 1);
        chk("aw_addr", awaddr, 'h10);
        chk("w_data", wdata, 'hAA);
        tick(); #1;
        chk("aw_drop", awvalid, 0);
        chk("w_drop", wvalid, 0);
        bvalid = 1; tick(); bvalid = 0; #1;
        chk("wr_done_pulse", wr_done, 1);
        tick(); #1;
        chk("wr_done_once", wr_done, 0);
        req_valid = 1; req_write = 0; req_addr = 'h10; #1;
        chk("rd_req_ready", req_ready, 1);
        tick(); req_valid = 0; #1;
        chk("ar_valid", arvalid, 1);
        chk("ar_addr", araddr, 'h10);
        chk("ar_id", arid, 0);
        tick(); #1;
        chk("ar_drop", arvalid, 0);
        rvalid = 1; rid = 0; rdata = 'hAA; tick(); rvalid = 0; #1;
        chk("rsp_valid", rd_rsp_valid, 1);
        chk("rsp_id", rd_rsp_id, 0);
        chk("rsp_addr", rd_rsp_addr, 'h10);
        chk("rsp_data", rd_rsp_data, 'hAA);
        tick(); #1;
        chk("rsp_drain", rd_rsp_valid, 0);

        // unwritten slave location returns X data
        req_valid = 1; req_write = 0; req_addr = 'h20;
        tick(); req_valid = 0;
        tick();
        rvalid = 1; rid = 0; rdata = 'x; tick(); rvalid = 0; rdata = '0; #1;
        chk("x_rsp_addr", rd_rsp_addr, 'h20);
        chk("x_passthrough", rd_rsp_data, x_data);
        chk("x_no_err", protocol_err, 0);

        // exhaust the ID pool
        for (int i = 0; i < n_ids; i++) begin
            req_valid = 1; req_write = 0; req_addr = 32'(4 * i); #1;
            chk("fill_ready", req_ready, 1);
            tick(); #1;
            chk("fill_arvalid", arvalid, 1);
            chk("fill_arid", arid, i);
            chk("fill_araddr", araddr, 4 * i);
        end
        req_addr = 'h10; #1;
        chk("full_rd_stall", req_ready, 0);
        req_write = 1; req_wdata = 'h55; #1;
        chk("full_wr_ok", req_ready, 1);
        tick(); req_valid = 0; #1;
        chk("full_wr_aw", awvalid, 1);
        tick(); bvalid = 1; tick(); bvalid = 0; #1;
        chk("full_wr_done", wr_done, 1);

        // out-of-order returns; freed ID reusable only from the next cycle
        rvalid = 1; rid = 3; rdata = 'h300;
        req_valid = 1; req_write = 0; req_addr = 'h40; #1;
        chk("reuse_not_same_cycle", req_ready, 0);
        tick(); rvalid = 0; #1;
        chk("rev_id3", rd_rsp_id, 3);
        chk("rev_addr3", rd_rsp_addr, 'hC);
        chk("rev_data3", rd_rsp_data, 'h300);
        chk("reuse_ready", req_ready, 1);
        tick(); req_valid = 0; #1;
        chk("reuse_arid", arid, 3);
        chk("reuse_araddr", araddr, 'h40);
        for (int j = 0; j < 4; j++) begin
            rvalid = 1; rid = id_t'(rev_id[j]); rdata = 32'h1000 + 32'(j);
            tick(); rvalid = 0; #1;
            chk("rev_valid", rd_rsp_valid, 1);
            chk("rev_id", rd_rsp_id, rev_id[j]);
            chk("rev_addr", rd_rsp_addr, rev_addr[j]);
            chk("rev_data", rd_rsp_data, 32'h1000 + 32'(j));
        end

        // outstanding write limit
        wd_base = wd_seen;
        for (int i = 0; i < 5; i++) begin
            req_valid = 1; req_write = 1; req_addr = 32'h100 + 32'(8 * i); req_wdata = 32'(i); #1;
            chk("wlim_ready", req_ready, i < MAXW);
            if (i < MAXW) tick();
        end
        tick(); #1;
        chk("wlim_hold", req_ready, 0);
        bvalid = 1; #1;
        chk("wlim_b_same_cycle", req_ready, 0);
        tick(); bvalid = 0; #1;
        chk("wlim_done", wr_done, 1);
        chk("wlim_release", req_ready, 1);
        tick(); req_valid = 0; #1;
        chk("wlim_fifth_aw", awvalid, 1);
        chk("wlim_fifth_addr", awaddr, 'h120);
        bvalid = 1; repeat (4) tick(); bvalid = 0;
        tick(); tick(); #1;
        chk("wlim_done_total", wd_seen - wd_base, 5);

        // W channel stalled while AW is taken
        wready = 0;
        req_valid = 1; req_write = 1; req_addr = 'h80; req_wdata = 'h1234; #1;
        chk("wst_ready", req_ready, 1);
        tick(); req_addr = 'h84; req_wdata = 'h5678; #1;
        chk("wst_aw", awvalid, 1);
        chk("wst_w", wvalid, 1);
        chk("wst_block0", req_ready, 0);
        for (int k = 0; k < 2; k++) begin
            tick(); #1;
            chk("wst_aw_drop", awvalid, 0);
            chk("wst_w_hold", wvalid, 1);
            chk("wst_wdata_hold", wdata, 'h1234);
            chk("wst_block", req_ready, 0);
        end
        tick(); wready = 1; #1;
        chk("wst_w_last", wvalid, 1);
        chk("wst_wdata_last", wdata, 'h1234);
        chk("wst_release", req_ready, 1);
        tick(); req_valid = 0; #1;
        chk("wst_next_aw", awaddr, 'h84);
        chk("wst_next_w", wdata, 'h5678);
        tick(); #1;
        chk("wst_next_w_drop", wvalid, 0);
        bvalid = 1; tick(); tick(); bvalid = 0; tick();

        // unexpected responses
        rvalid = 1; rid = 1; rdata = 'hDEAD; tick(); rvalid = 0; #1;
        chk("perr_r", protocol_err, 1);
        chk("perr_r_no_rsp", rd_rsp_valid, 0);
        bvalid = 1; tick(); bvalid = 0; #1;
        chk("perr_b_no_done", wr_done, 0);
        tick(); tick(); #1;
        chk("perr_sticky", protocol_err, 1);
        for (int i = 0; i < MAXW; i++) begin
            req_valid = 1; req_write = 1; req_addr = 32'h200 + 32'(4 * i); req_wdata = 32'(i); #1;
            chk("no_underflow_ready", req_ready, 1);
            tick();
        end

        // asynchronous reset with traffic in flight
        awready = 0; wready = 0; arready = 0;
        req_write = 0; req_addr = 'h300; #1;
        chk("pre_rst_rd_ready", req_ready, 1);
        tick(); req_valid = 0; #1;
        chk("pre_rst_ar", arvalid, 1);
        chk("pre_rst_aw", awvalid, 1);
        chk("pre_rst_w", wvalid, 1);
        #2; rst = 0; #1;
        chk("async_ar", arvalid, 0);
        chk("async_aw", awvalid, 0);
        chk("async_w", wvalid, 0);
        chk("async_perr", protocol_err, 0);
        chk("async_bready", bready, 0);
        quiet();
        @(posedge clk); #1; rst = 1;
        tick();
        rvalid = 1; rid = 0; rdata = 'h77; tick(); rvalid = 0; #1;
        chk("stale_id_perr", protocol_err, 1);
        chk("stale_id_no_rsp", rd_rsp_valid, 0);

        // randomized traffic against the scoreboard
        do_reset();
        for (int i = 0; i < n_ids; i++) m_busy[i] = 0;
        m_wout = 0; aw_cnt = 0; w_cnt = 0; b_issued = 0; b_acked = 0; wr_accepted = 0;
        f_req = 0; f_r = 0; f_b = 0;
        wd_base = wd_seen;
        for (int cyc = 0; cyc < 1600; cyc++) begin
            if (f_req) req_valid = 0;
            if (f_r) rvalid = 0;
            if (f_b) bvalid = 0;
            if (!req_valid && cyc < 1200 && $urandom_range(0, 3) != 0) begin
                req_valid = 1;
                req_write = 1'($urandom_range(0, 1));
                req_addr  = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
                req_wdata = $urandom;
            end
            arready      = ($urandom_range(0, 3) != 0);
            awready      = ($urandom_range(0, 3) != 0);
            wready       = ($urandom_range(0, 3) != 0);
            rd_rsp_ready = ($urandom_range(0, 3) != 0);
            if (!rvalid && pend_rd.size() > 0 && $urandom_range(0, 1) == 0) begin
                pick = $urandom_range(0, pend_rd.size() - 1);
                rid = pend_rd[pick];
                pend_rd.delete(pick);
                rdata = $urandom;
                rvalid = 1;
            end
            if (!bvalid && ((aw_cnt < w_cnt) ? aw_cnt : w_cnt) > b_issued && $urandom_range(0, 1) == 0) begin
                bvalid = 1;
                b_issued++;
            end
            #1;
            f_req = req_valid && req_ready;
            f_ar  = arvalid && arready;
            f_aw  = awvalid && awready;
            f_w   = wvalid && wready;
            f_r   = rvalid && rready;
            f_b   = bvalid && bready;
            f_rsp = rd_rsp_valid && rd_rsp_ready;
            if (req_valid && !req_write && model_lowest_free() < 0) chk("rnd_rd_full_stall", req_ready, 0);
            if (req_valid && req_write && m_wout >= MAXW) chk("rnd_wr_limit_stall", req_ready, 0);
            if (f_rsp) begin
                chk("rnd_rsp_expected", exp_rsp.size() > 0, 1);
                if (exp_rsp.size() > 0) begin
                    e = exp_rsp.pop_front();
                    chk("rnd_rsp_id", rd_rsp_id, e.id);
                    chk("rnd_rsp_addr", rd_rsp_addr, e.addr);
                    chk("rnd_rsp_data", rd_rsp_data, e.data);
                end
            end
            if (f_ar) begin
                chk("rnd_ar_expected", exp_ar_id.size() > 0, 1);
                if (exp_ar_id.size() > 0) begin
                    chk("rnd_arid", arid, exp_ar_id.pop_front());
                    chk("rnd_araddr", araddr, exp_ar_addr.pop_front());
                end
                pend_rd.push_back(arid);
            end
            if (f_aw) begin
                chk("rnd_aw_expected", exp_aw.size() > 0, 1);
                if (exp_aw.size() > 0) chk("rnd_awaddr", awaddr, exp_aw.pop_front());
                aw_cnt++;
            end
            if (f_w) begin
                chk("rnd_w_expected", exp_w.size() > 0, 1);
                if (exp_w.size() > 0) chk("rnd_wdata", wdata, exp_w.pop_front());
                w_cnt++;
            end
            if (f_req) begin
                if (req_write) begin
                    chk("rnd_wr_within_limit", m_wout < MAXW, 1);
                    m_wout++;
                    wr_accepted++;
                    exp_aw.push_back(req_addr);
                    exp_w.push_back(req_wdata);
                end else begin
                    fid = model_lowest_free();
                    chk("rnd_rd_id_available", fid >= 0, 1);
                    if (fid >= 0) begin
                        m_busy[fid] = 1;
                        m_addr[fid] = req_addr;
                        exp_ar_id.push_back(id_t'(fid));
                        exp_ar_addr.push_back(req_addr);
                    end
                end
            end
            if (f_r) begin
                exp_rsp.push_back('{id: rid, addr: m_addr[rid], data: rdata});
                m_busy[rid] = 0;
            end
            if (f_b) begin
                m_wout--;
                b_acked++;
            end
            tick();
        end
        tick(); #1;
        chk("rnd_ar_drained", exp_ar_id.size(), 0);
        chk("rnd_aw_drained", exp_aw.size(), 0);
        chk("rnd_w_drained", exp_w.size(), 0);
        chk("rnd_rsp_drained", exp_rsp.size(), 0);
        chk("rnd_b_all", b_acked, wr_accepted);
        chk("rnd_wr_done_count", wd_seen - wd_base, b_acked);
        chk("rnd_no_perr", protocol_err, 0);
        chk("rnd_rsp_idle", rd_rsp_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/axi_master_ctrl.md
Name: axi_master_ctrl

Overview:
Synthesizable master for the team's simplified AXI (SAXI) interface, and the initiator counterpart of the SAXI slave model. It turns a single user request stream (read or write) into AR, AW and W channel traffic. It allocates read IDs from a free pool so read data may return out of order, and counts outstanding writes against in-order B responses. It sits between a user/test driver and any SAXI slave or interconnect.

Parameters:
MAX_WR_OUT, 4, maximum outstanding writes (AW accepted, B not yet received); range 1..15
CNT_W, 4, width of the write-outstanding counter; must satisfy 2**CNT_W > MAX_WR_OUT

Ports:
clk  in  1  clock; all logic on the rising edge
rst  in  1  asynchronous, active-low reset
req_valid  in  1  user request valid
req_ready  out  1  user request accepted when req_valid & req_ready
req_write  in  1  1 = write, 0 = read
req_addr  in  addr_t  request address
req_wdata  in  data_t  write data; ignored for reads
rd_rsp_valid  out  1  read completion valid
rd_rsp_ready  in  1  read completion accepted
rd_rsp_id  out  id_t  ID the read used
rd_rsp_addr  out  addr_t  original address of the read
rd_rsp_data  out  data_t  returned read data
wr_done  out  1  one-cycle pulse per B handshake
protocol_err  out  1  sticky; set on any unexpected response
araddr / arid / arvalid  out  addr_t / id_t / 1  read address channel
arready  in  1
awaddr / awvalid  out  addr_t / 1  write address channel
awready  in  1
wdata / wvalid  out  data_t / 1  write data channel
wready  in  1
rdata / rid / rvalid  in  data_t / id_t / 1  read data channel
rready  out  1
bvalid  in  1  write response
bready  out  1  constant 1 out of reset

Behaviour:
- Reset (rst low, asynchronous): arvalid, awvalid, wvalid, rd_rsp_valid, wr_done and protocol_err go to 0. id_busy is all 0. wr_cnt is 0. Data and address outputs are don't-care. bready is 0 during reset and 1 otherwise.
- All channel outputs are registered. A valid signal, once raised, stays high with stable payload until its ready handshake. There are no combinational paths from arready, awready or wready to the matching valid.
- Read accept:
  - req_ready is 1 when (!arvalid | arready) and at least one id_busy bit is clear.
  - On accept, the master takes the lowest-index free ID, sets id_busy[id] and stores id_addr[id] = req_addr.
  - Next cycle: arvalid=1, araddr=req_addr, arid=id.
- Write accept:
  - req_ready is 1 when (!awvalid | awready) & (!wvalid | wready) & (wr_cnt < MAX_WR_OUT).
  - On accept, awvalid and wvalid rise together next cycle. Each then drops independently on its own handshake; the slave may take AW and W in any order or cycle.
  - wr_cnt increments on accept.
- req_ready is a function of req_write plus state, and is combinational from req_write.
- Back-to-back: a new request is accepted in the same cycle the previous one's handshake completes, giving a throughput of 1 per cycle when readies are held high.
- Read response:
  - rready = !rd_rsp_valid | rd_rsp_ready. The output register forms a one-entry stage.
  - On rvalid & rready: rd_rsp_valid=1 next cycle with rd_rsp_id=rid, rd_rsp_addr=id_addr[rid], rd_rsp_data=rdata. id_busy[rid] is cleared in the same edge.
  - A freed ID may be reallocated by a request accepted in the next cycle (not the same cycle).
  - If id_busy[rid] is 0 when R arrives: protocol_err is set, the response is dropped, and nothing is emitted.
- Write response:
  - On bvalid with wr_cnt>0: wr_done pulses next cycle and wr_cnt decrements.
  - On bvalid with wr_cnt==0: protocol_err is set and wr_cnt stays 0 (no underflow).
  - Write accept and B in the same cycle leave wr_cnt unchanged.
- X handling: rdata may be X (an unwritten slave location). It passes through unchanged and is not an error.
- Reset mid-operation: all outstanding state is discarded. Responses arriving after reset for pre-reset IDs set protocol_err.

Decomposition:
- Package axi_transaction: addr_t, data_t, id_t, n_ids (= 2**id width).
- Sub-module axi_id_alloc: holds id_busy and id_addr. Provides a lowest-free priority encoder, alloc and free ports, an address lookup by ID, and a "none free" flag.

Test Plan:
- Write 0x10=0xAA, then read 0x10, against a slave with 100% readiness -> AW and W issued 1 cycle after accept; wr_done once; rd_rsp_addr=0x10, rd_rsp_data=0xAA, rd_rsp_id=0.
- Issue n_ids reads to 0x0, 0x4, 0x8, ... with no R returned -> IDs 0..n_ids-1 assigned in order; req_ready=0 for the next read; a write is still accepted.
- Slave returns R for IDs in reverse order -> each rd_rsp carries the matching stored addr; the freed ID is reused by the next read one cycle later.
- Five writes with MAX_WR_OUT=4, bvalid held 0 -> four accepted, fifth stalls; one B -> fifth accepted next cycle; total five wr_done.
- awready=1, wready held 0 for 3 cycles -> awvalid drops after 1 cycle; wvalid/wdata stay stable 4 cycles; no new write accepted meanwhile.
- Inject rvalid with an idle rid, and bvalid with wr_cnt=0 -> protocol_err=1 and stays 1; no rd_rsp or wr_done; async rst low mid-burst -> all valids 0 immediately.
